// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared constants, state type and DIN word helper for the ADC scan controller
package adc_scan_pkg;

  localparam int NUM_CH     = 8;
  localparam int CH_W       = 3;
  localparam int DATA_W     = 12;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 4;
  localparam int ADDR_POS   = 11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    PRIME,
    CONV,
    GAP
  } state_t;

  // Frame word shifted out on DIN: two leading zeros, channel address, then zeros.
  function automatic logic [FRAME_BITS-1:0] din_word(input logic [CH_W-1:0] addr);
    din_word = '0;
    din_word[ADDR_POS +: CH_W] = addr;
  endfunction

endpackage

// File: rtl/adc_ch_scan.sv
// rtl/adc_ch_scan.sv - combinational channel picker: lowest enabled channel and next enabled channel with wrap
module adc_ch_scan
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic [CH_W-1:0]   low_ch
);

  // Scanning downward lets the last hit be the lowest qualifying channel.
  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) low_ch = CH_W'(i);
    end
    next_ch = low_ch;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (CH_W'(i) > cur_ch)) next_ch = CH_W'(i);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - sequencer for an 8-channel 12-bit serial ADC: frames, channel scan, tagged samples
module adc_scan_ctrl
  import adc_scan_pkg::*;
(
  input  logic              wb_clk,
  input  logic              rst_pad_i,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [2:0]        speed_sel,
  input  logic              adc_clk,
  input  logic              adc_dout,
  output logic [2:0]        clk_speed_select,
  output logic              adc_cs_n,
  output logic              adc_din,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch
);

  state_t state, state_nxt;

  logic                  adc_clk_d, rise, fall;
  logic [NUM_CH-1:0]     mask_r;
  logic                  cont_r, stop_flag, gap_hi, was_conv;
  logic [FRAME_BITS-1:0] din_sr;
  logic [DATA_W-2:0]     cap_sr;
  logic [DATA_W-1:0]     cap_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CH_W-1:0]       cur_ch, prev_ch, next_ch, low_ch, frame_ch;
  logic                  accept, in_frame, frame_done, scan_done, gap_close, frame_start;

  adc_ch_scan u_ch_scan (
    .mask    (mask_r),
    .cur_ch  (cur_ch),
    .next_ch (next_ch),
    .low_ch  (low_ch)
  );

  assign rise     = adc_clk & ~adc_clk_d;
  assign fall     = ~adc_clk & adc_clk_d;
  assign cap_next = {cap_sr, adc_dout};
  assign adc_din  = din_sr[FRAME_BITS-1];

  always_ff @(posedge wb_clk) begin
    if (rst_pad_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept) state_nxt = WAIT_FALL;
      WAIT_FALL:   if (fall) state_nxt = PRIME;
      PRIME, CONV: if (frame_done) state_nxt = GAP;
      GAP: begin
        if (gap_close && scan_done) state_nxt = IDLE;
        else if (frame_start)       state_nxt = CONV;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  // The scan ends after the frame that carried the wrapped (lowest) address,
  // or, in continuous mode, after whichever frame was running when stop came.
  always_comb begin
    accept      = (state == IDLE) && start && (ch_mask != '0);
    in_frame    = (state == PRIME) || (state == CONV);
    frame_done  = in_frame && rise && (bit_cnt == CNT_W'(FRAME_BITS - 1));
    scan_done   = cont_r ? stop_flag : (was_conv && (cur_ch == low_ch));
    gap_close   = (state == GAP) && fall && !gap_hi;
    frame_start = fall && ((state == WAIT_FALL) || ((state == GAP) && gap_hi));
    frame_ch    = (state == WAIT_FALL) ? low_ch : next_ch;
  end

  always_ff @(posedge wb_clk) begin
    if (rst_pad_i) begin
      adc_clk_d        <= 1'b0;
      mask_r           <= '0;
      cont_r           <= 1'b0;
      stop_flag        <= 1'b0;
      gap_hi           <= 1'b0;
      was_conv         <= 1'b0;
      din_sr           <= '0;
      cap_sr           <= '0;
      bit_cnt          <= '0;
      cur_ch           <= '0;
      prev_ch          <= '0;
      clk_speed_select <= '0;
      adc_cs_n         <= 1'b1;
      busy             <= 1'b0;
      sample_valid     <= 1'b0;
      sample_data      <= '0;
      sample_ch        <= '0;
    end else begin
      adc_clk_d    <= adc_clk;
      sample_valid <= 1'b0;

      if (accept) begin
        mask_r           <= ch_mask;
        cont_r           <= continuous;
        clk_speed_select <= speed_sel;
        busy             <= 1'b1;
        stop_flag        <= 1'b0;
      end

      if (stop && cont_r && (state != IDLE)) stop_flag <= 1'b1;

      if (frame_start) begin
        adc_cs_n <= 1'b0;
        gap_hi   <= 1'b0;
        bit_cnt  <= '0;
        prev_ch  <= cur_ch;
        cur_ch   <= frame_ch;
        din_sr   <= din_word(frame_ch);
        was_conv <= (state == GAP);
      end else if (in_frame && fall) begin
        din_sr <= din_sr << 1;
      end

      if (in_frame && rise) begin
        cap_sr  <= cap_next[DATA_W-2:0];
        bit_cnt <= bit_cnt + 1'b1;
      end

      // The ADC returns the previous frame's conversion, hence prev_ch.
      if (frame_done && (state == CONV)) begin
        sample_valid <= 1'b1;
        sample_data  <= cap_next;
        sample_ch    <= prev_ch;
      end

      if (gap_close) begin
        adc_cs_n <= 1'b1;
        gap_hi   <= 1'b1;
        if (scan_done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - scoreboard bench for adc_scan_ctrl with divider and serial ADC models
module tb_adc_scan_ctrl;

  logic        wb_clk = 1'b0;
  logic        rst_pad_i = 1'b1;
  logic        start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [2:0]  speed_sel = '0;
  logic        adc_clk = 1'b0, adc_dout = 1'b0;
  logic [2:0]  clk_speed_select;
  logic        adc_cs_n, adc_din, busy, sample_valid;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  int checks = 0, failures = 0;
  int strobes = 0, cs_falls = 0;
  logic [11:0] chan_val [8];
  logic [14:0] exp_q [$];
  logic [2:0]  addr_log [$];
  logic [2:0]  exp_addr [$];
  int          low_runs [$], high_runs [$];

  adc_scan_ctrl dut (
    .wb_clk(wb_clk), .rst_pad_i(rst_pad_i), .start(start), .continuous(continuous),
    .stop(stop), .ch_mask(ch_mask), .speed_sel(speed_sel), .adc_clk(adc_clk),
    .adc_dout(adc_dout), .clk_speed_select(clk_speed_select), .adc_cs_n(adc_cs_n),
    .adc_din(adc_din), .busy(busy), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ch(sample_ch)
  );

  always #5 wb_clk = ~wb_clk;

  // Clock divider: adc_clk toggles every 2^s wb_clk cycles.
  int div_cnt = 0;
  always @(posedge wb_clk) begin
    if (div_cnt >= (1 << clk_speed_select) - 1) begin
      div_cnt <= 0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Serial ADC: latches the address of a complete frame, answers it in the next frame.
  logic        m_prev_clk = 1'b0, m_cs_prev = 1'b1, pend_ok = 1'b0;
  logic [2:0]  pend_addr = '0;
  logic [15:0] out_m = '0, din_m = '0;
  int          rises_m = 0;
  always @(negedge wb_clk) begin
    if (!adc_cs_n && m_cs_prev) begin
      out_m    = pend_ok ? {4'b0, chan_val[pend_addr]} : 16'($urandom);
      adc_dout = out_m[15];
      rises_m  = 0;
      din_m    = '0;
    end else if (!adc_cs_n && !adc_clk && m_prev_clk) begin
      out_m    = out_m << 1;
      adc_dout = out_m[15];
    end
    if (adc_cs_n && !m_cs_prev) begin
      pend_ok   = (rises_m == 16);
      pend_addr = din_m[13:11];
      if (pend_ok) addr_log.push_back(din_m[13:11]);
    end
    if (!adc_cs_n && adc_clk && !m_prev_clk) begin
      din_m = {din_m[14:0], adc_din};
      rises_m++;
    end
    m_prev_clk = adc_clk;
    m_cs_prev  = adc_cs_n;
  end

  // Scoreboard monitor.
  logic prev_valid = 1'b0;
  logic [14:0] exp_item;
  always @(negedge wb_clk) begin
    if (!rst_pad_i && sample_valid) begin
      strobes++;
      check("valid_single_cycle", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample actual=ch%0d/%0h required=none", sample_ch, sample_data);
      end else begin
        exp_item = exp_q.pop_front();
        check("sample", {17'b0, sample_ch, sample_data}, {17'b0, exp_item});
      end
    end
    prev_valid = sample_valid;
  end

  // Chip-select run lengths and frame starts.
  int low_run = 0, high_run = 0;
  logic cs_prev_t = 1'b1;
  always @(negedge wb_clk) begin
    if (adc_cs_n) begin
      if (!cs_prev_t) low_runs.push_back(low_run);
      high_run++;
      low_run = 0;
    end else begin
      if (cs_prev_t) begin
        cs_falls++;
        high_runs.push_back(high_run);
      end
      low_run++;
      high_run = 0;
    end
    cs_prev_t = adc_cs_n;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic do_start(input logic [7:0] m, input logic [2:0] s, input logic c);
    ch_mask = m; speed_sel = s; continuous = c; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    ch_mask = 8'($urandom); speed_sel = 3'($urandom); continuous = 1'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20000) begin @(negedge wb_clk); n++; end
    check({name, "_finishes"}, {31'b0, busy}, 32'd0);
    tick(2);
  endtask

  task automatic wait_count(input string name, input bit use_strobes, input int target);
    int n = 0;
    while (((use_strobes ? strobes : cs_falls) < target) && n < 20000) begin
      @(negedge wb_clk); n++;
    end
    check({name, "_reached"}, 32'((use_strobes ? strobes : cs_falls) >= target), 32'd1);
  endtask

  task automatic wait_rises(input int k);
    int n = 0, r = 0;
    logic p;
    p = adc_clk;
    while (r < k && n < 5000) begin
      @(negedge wb_clk); n++;
      if (adc_clk && !p) r++;
      p = adc_clk;
    end
  endtask

  // Reference: a single pass reports every enabled channel in ascending order;
  // DIN carries those addresses followed by the lowest one again.
  task automatic expect_single(input logic [7:0] m);
    int first = -1;
    exp_addr.delete();
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        if (first < 0) first = c;
        exp_q.push_back({3'(c), chan_val[c]});
        exp_addr.push_back(3'(c));
      end
    end
    exp_addr.push_back(3'(first));
  endtask

  task automatic check_addr_log(input string name);
    check({name, "_addr_count"}, addr_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
      check({name, "_addr"}, {29'b0, addr_log[i]}, {29'b0, exp_addr[i]});
  endtask

  int base;
  logic [7:0] rmask;
  logic [2:0] rspeed;

  initial begin
    for (int i = 0; i < 8; i++) chan_val[i] = 12'($urandom);
    tick(3);
    check("rst_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("rst_din", {31'b0, adc_din}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, sample_valid}, 32'd0);
    check("rst_data_ch", {17'b0, sample_ch, sample_data}, 32'd0);
    check("rst_speed", {29'b0, clk_speed_select}, 32'd0);
    rst_pad_i = 1'b0;
    tick(4);

    // Single channel, one pass.
    chan_val[0] = 12'hABC;
    base = strobes; addr_log.delete();
    expect_single(8'h01);
    do_start(8'h01, 3'd0, 1'b0);
    wait_idle("t1");
    check("t1_strobes", strobes - base, 32'd1);
    check("t1_speed", {29'b0, clk_speed_select}, 32'd0);
    check("t1_drained", exp_q.size(), 32'd0);
    check_addr_log("t1");

    // Sparse mask, stop pulse during a single pass is ignored.
    base = strobes; addr_log.delete();
    expect_single(8'hA4);
    do_start(8'hA4, 3'd0, 1'b0);
    tick(50); stop = 1'b1; tick(1); stop = 1'b0;
    wait_idle("t2");
    check("t2_strobes", strobes - base, 32'd3);
    check("t2_drained", exp_q.size(), 32'd0);
    check_addr_log("t2");

    // Continuous scan stopped in the middle of frame 5.
    base = strobes;
    for (int c = 0; c < 4; c++) exp_q.push_back({3'(c), chan_val[c]});
    do_start(8'hFF, 3'd3, 1'b1);
    wait_count("t3_third_sample", 1'b1, base + 3);
    wait_count("t3_frame5", 1'b0, cs_falls + 1);
    wait_rises(6);
    stop = 1'b1; tick(1); stop = 1'b0;
    check("t3_busy_during_frame5", {31'b0, busy}, 32'd1);
    wait_idle("t3");
    check("t3_strobes", strobes - base, 32'd4);
    check("t3_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("t3_drained", exp_q.size(), 32'd0);

    // Empty mask is ignored.
    base = cs_falls;
    do_start(8'h00, 3'd2, 1'b0);
    tick(20);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("t4_no_frames", cs_falls - base, 32'd0);

    // Speed 1: frame/gap lengths, speed_sel changes while busy ignored.
    low_runs.delete(); high_runs.delete();
    expect_single(8'h06);
    do_start(8'h06, 3'd1, 1'b0);
    speed_sel = 3'd5;
    tick(10);
    check("t6_speed_held", {29'b0, clk_speed_select}, 32'd1);
    wait_idle("t6");
    check("t6_speed_after", {29'b0, clk_speed_select}, 32'd1);
    check("t6_frames", low_runs.size(), 32'd3);
    foreach (low_runs[i]) check("t6_cs_low_len", low_runs[i], 32'd64);
    for (int i = 1; i < high_runs.size(); i++) check("t6_gap_ge4", 32'(high_runs[i] >= 4), 32'd1);
    check("t6_drained", exp_q.size(), 32'd0);

    // Reset at bit 9 of the first CONV frame, then a fresh scan.
    expect_single(8'h01);
    base = cs_falls;
    do_start(8'h01, 3'd0, 1'b0);
    wait_count("t5_conv_start", 1'b0, base + 2);
    wait_rises(9);
    base = strobes;
    rst_pad_i = 1'b1;
    tick(2);
    exp_q.delete();
    check("t5_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("t5_busy", {31'b0, busy}, 32'd0);
    rst_pad_i = 1'b0;
    tick(60);
    check("t5_no_strobe", strobes - base, 32'd0);
    base = cs_falls;
    expect_single(8'h01);
    do_start(8'h01, 3'd0, 1'b0);
    wait_idle("t5b");
    check("t5_fresh_frames", cs_falls - base, 32'd2);
    check("t5_drained", exp_q.size(), 32'd0);

    // Randomized single passes.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) chan_val[i] = 12'($urandom);
      rmask  = 8'($urandom_range(1, 255));
      rspeed = 3'($urandom_range(0, 2));
      addr_log.delete();
      expect_single(rmask);
      do_start(rmask, rspeed, 1'b0);
      wait_idle("rand");
      check("rand_speed", {29'b0, clk_speed_select}, {29'b0, rspeed});
      check("rand_drained", exp_q.size(), 32'd0);
      check_addr_log("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
